pipeline_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage toy CPU (PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Merges per-stage stall requests, including the ID-stage load-use stall, into one nested stall vector.
- Sequences branch redirects: issues them at once, or defers them while a downstream stall is active.
- Runs a halt/drain state machine and keeps a stall-cycle performance counter with a stuck-stall watchdog.

---
 rtl/pipeline_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences branch redirects, runs halt/drain, counts stalls.
// Latency: o_stall/o_pcLoad/o_newPc/o_flush are combinational; o_stallCount/o_timeout/o_halted register one cycle later.
// Backpressure: a redirect waits in PENDING while an EX/MEM stall holds ID/EX; EX/MEM stalls also extend DRAIN.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_LIMIT   = 1023,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ifStallReq,
  input  logic                 i_idStallReq,
  input  logic                 i_exStallReq,
  input  logic                 i_memStallReq,
  input  logic                 i_branchTaken,
  input  logic [31:0]          i_branchTarget,
  input  logic                 i_halt,
  output logic [4:0]           o_stall,
  output logic                 o_pcLoad,
  output logic [31:0]          o_newPc,
  output logic                 o_flush,
  output logic [CNT_WIDTH-1:0] o_stallCount,
  output logic                 o_timeout,
  output logic                 o_halted
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  localparam logic [4:0] IF_VEC  = 5'b00001;
  localparam logic [4:0] ID_VEC  = 5'b00011;
  localparam logic [4:0] EX_VEC  = 5'b00111;
  localparam logic [4:0] MEM_VEC = 5'b01111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [31:0]     pend_target;
  logic            halt_pend, halt_pend_next;
  logic [DW-1:0]   drain_cnt, drain_next;
  logic [WW-1:0]   wdog_cnt, wdog_next;
  logic            latch_target;
  logic            count_en;
  logic [4:0]      req_vec;
  logic [4:0]      ds_vec;
  logic            ds_stall;

  // Nested per-request stall vectors; an EX or MEM request means ID/EX is held.
  always_comb begin
    ds_vec = 5'b00000;
    if (i_exStallReq)  ds_vec = ds_vec | EX_VEC;
    if (i_memStallReq) ds_vec = ds_vec | MEM_VEC;
    req_vec = ds_vec;
    if (i_ifStallReq)  req_vec = req_vec | IF_VEC;
    if (i_idStallReq)  req_vec = req_vec | ID_VEC;
    ds_stall = |ds_vec[4:2];
  end

  // Next-state and combinational outputs for the run/pending/drain/halted sequencer.
  always_comb begin
    next_state     = state;
    halt_pend_next = halt_pend;
    drain_next     = drain_cnt;
    latch_target   = 1'b0;
    count_en       = 1'b0;
    o_stall        = 5'b00000;
    o_pcLoad       = 1'b0;
    o_newPc        = 32'd0;
    o_flush        = 1'b0;

    case (state)
      ST_RUN: begin
        o_stall  = req_vec;
        count_en = 1'b1;
        if (i_branchTaken && ds_stall) begin
          // ID/EX is held, so the redirect cannot enter yet; park it.
          latch_target   = 1'b1;
          halt_pend_next = i_halt;
          next_state     = ST_PENDING;
        end else begin
          if (i_branchTaken) begin
            o_pcLoad = 1'b1;
            o_newPc  = i_branchTarget;
            o_flush  = 1'b1;
          end
          if (i_halt) begin
            next_state = ST_DRAIN;
            drain_next = DW'(DRAIN_CYCLES - 1);
          end
        end
      end

      ST_PENDING: begin
        o_stall  = req_vec;
        count_en = 1'b1;
        if (i_halt) halt_pend_next = 1'b1;
        if (!ds_stall) begin
          o_pcLoad       = 1'b1;
          o_newPc        = pend_target;
          o_flush        = 1'b1;
          halt_pend_next = 1'b0;
          if (halt_pend || i_halt) begin
            next_state = ST_DRAIN;
            drain_next = DW'(DRAIN_CYCLES - 1);
          end else begin
            next_state = ST_RUN;
          end
        end
      end

      ST_DRAIN: begin
        // PC frozen, bubbles injected; downstream stalls stretch the drain.
        o_stall = IF_VEC | ds_vec;
        o_flush = 1'b1;
        if (!ds_stall) begin
          if (drain_cnt == '0) next_state = ST_HALTED;
          else                 drain_next = drain_cnt - 1'b1;
        end
      end

      ST_HALTED: begin
        o_stall = MEM_VEC;
      end

      default: begin
        next_state = ST_RUN;
      end
    endcase

    // Keep every output quiet while reset is asserted.
    if (rst) begin
      o_stall  = 5'b00000;
      o_pcLoad = 1'b0;
      o_newPc  = 32'd0;
      o_flush  = 1'b0;
    end
  end

  // Watchdog run length: only stalls seen while running count; drain/halt stalls are intentional.
  always_comb begin
    wdog_next = '0;
    if (count_en && (o_stall != 5'b00000)) begin
      wdog_next = (wdog_cnt == WW'(WDOG_LIMIT)) ? wdog_cnt : wdog_cnt + 1'b1;
    end
  end

  // State, pending redirect and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pend_target <= 32'd0;
      halt_pend   <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      state     <= next_state;
      halt_pend <= halt_pend_next;
      drain_cnt <= drain_next;
      if (latch_target) pend_target <= i_branchTarget;
    end
  end

  // Saturating stall counter, sticky watchdog flag and halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stallCount <= '0;
      wdog_cnt     <= '0;
      o_timeout    <= 1'b0;
      o_halted     <= 1'b0;
    end else begin
      if (count_en && (o_stall != 5'b00000) && (o_stallCount != {CNT_WIDTH{1'b1}})) begin
        o_stallCount <= o_stallCount + 1'b1;
      end
      wdog_cnt  <= wdog_next;
      o_timeout <= o_timeout | (wdog_next == WW'(WDOG_LIMIT));
      o_halted  <= (next_state == ST_HALTED);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        i_ifStallReq, i_idStallReq, i_exStallReq, i_memStallReq;
  logic        i_branchTaken;
  logic [31:0] i_branchTarget;
  logic        i_halt;
  logic [4:0]  o_stall;
  logic        o_pcLoad;
  logic [31:0] o_newPc;
  logic        o_flush;
  logic [15:0] o_stallCount;
  logic        o_timeout;
  logic        o_halted;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(4), .WDOG_LIMIT(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_ifStallReq(i_ifStallReq), .i_idStallReq(i_idStallReq),
    .i_exStallReq(i_exStallReq), .i_memStallReq(i_memStallReq),
    .i_branchTaken(i_branchTaken), .i_branchTarget(i_branchTarget),
    .i_halt(i_halt),
    .o_stall(o_stall), .o_pcLoad(o_pcLoad), .o_newPc(o_newPc), .o_flush(o_flush),
    .o_stallCount(o_stallCount), .o_timeout(o_timeout), .o_halted(o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ifStallReq = 0; i_idStallReq = 0; i_exStallReq = 0; i_memStallReq = 0;
    i_branchTaken = 0; i_branchTarget = 32'd0; i_halt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    // Reset state
    chk("rst_stall", o_stall, 0);
    chk("rst_pcload", o_pcLoad, 0);
    chk("rst_newpc", o_newPc, 0);
    chk("rst_flush", o_flush, 0);
    chk("rst_cnt", o_stallCount, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_halted", o_halted, 0);
    rst = 0;

    // ID load-use stall alone
    i_idStallReq = 1; #1;
    chk("id_stall", o_stall, 5'b00011);
    step();
    i_idStallReq = 0; #1;
    chk("id_drop", o_stall, 5'b00000);
    chk("id_cnt", o_stallCount, 1);

    // MEM + IF stall, held 3 cycles
    do_reset();
    i_memStallReq = 1; i_ifStallReq = 1; #1;
    chk("mem_if_stall", o_stall, 5'b01111);
    step(); step(); step();
    clear_inputs(); #1;
    chk("mem_if_cnt", o_stallCount, 3);

    // Immediate branch
    i_branchTaken = 1; i_branchTarget = 32'h40; #1;
    chk("br_pcload", o_pcLoad, 1);
    chk("br_newpc", o_newPc, 32'h40);
    chk("br_flush", o_flush, 1);
    step();
    clear_inputs(); #1;
    chk("br_idle_pcload", o_pcLoad, 0);
    chk("br_idle_newpc", o_newPc, 0);

    // Branch deferred by EX stall; a second branch while pending is ignored
    i_exStallReq = 1; i_branchTaken = 1; i_branchTarget = 32'h80; #1;
    chk("def_c0_pcload", o_pcLoad, 0);
    chk("def_c0_stall", o_stall, 5'b00111);
    step();
    i_branchTarget = 32'h99; #1;
    chk("def_c1_pcload", o_pcLoad, 0);
    step();
    i_branchTaken = 0; #1;
    chk("def_c2_pcload", o_pcLoad, 0);
    step();
    i_exStallReq = 0; #1;
    chk("def_c3_pcload", o_pcLoad, 1);
    chk("def_c3_newpc", o_newPc, 32'h80);
    chk("def_c3_flush", o_flush, 1);
    step(); #1;
    chk("def_after_pcload", o_pcLoad, 0);

    // IF-only stall does not defer a branch
    i_ifStallReq = 1; i_branchTaken = 1; i_branchTarget = 32'h44; #1;
    chk("ifbr_stall", o_stall, 5'b00001);
    chk("ifbr_pcload", o_pcLoad, 1);
    chk("ifbr_newpc", o_newPc, 32'h44);
    step();
    clear_inputs();

    // Reset while pending leaves nothing pending
    i_exStallReq = 1; i_branchTaken = 1; i_branchTarget = 32'h300;
    step();
    do_reset(); #1;
    chk("rstpend_pcload", o_pcLoad, 0);
    step(); #1;
    chk("rstpend_pcload2", o_pcLoad, 0);

    // Halt in RUN: 4 drain cycles then halted
    do_reset();
    i_halt = 1; #1;
    chk("halt_run_flush", o_flush, 0);
    step();
    i_halt = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("drain%0d_stall", i), o_stall, 5'b00001);
      chk($sformatf("drain%0d_flush", i), o_flush, 1);
      chk($sformatf("drain%0d_halted", i), o_halted, 0);
      step();
    end
    chk("halted", o_halted, 1);
    chk("halted_stall", o_stall, 5'b01111);
    chk("halted_flush", o_flush, 0);
    chk("halted_cnt", o_stallCount, 0);
    i_branchTaken = 1; i_branchTarget = 32'h55; #1;
    chk("halted_br_ignored", o_pcLoad, 0);
    step();
    chk("halted_stays", o_halted, 1);
    clear_inputs();

    // Halt with MEM stall in drain cycles 2 and 3: two extra cycles
    do_reset();
    i_halt = 1;
    step();
    i_halt = 0;
    for (int i = 1; i <= 6; i++) begin
      i_memStallReq = (i == 2 || i == 3);
      #1;
      chk($sformatf("xdrain%0d_halted", i), o_halted, 0);
      if (i == 2) chk("xdrain_stall", o_stall, 5'b01111);
      step();
    end
    i_memStallReq = 0;
    chk("xdrain_halted", o_halted, 1);

    // Simultaneous halt and branch in RUN
    do_reset();
    i_halt = 1; i_branchTaken = 1; i_branchTarget = 32'h100; #1;
    chk("hb_pcload", o_pcLoad, 1);
    chk("hb_newpc", o_newPc, 32'h100);
    step();
    clear_inputs(); #1;
    chk("hb_drain_stall", o_stall, 5'b00001);
    chk("hb_drain_flush", o_flush, 1);

    // Halt while pending: redirect first, then drain
    do_reset();
    i_exStallReq = 1; i_branchTaken = 1; i_branchTarget = 32'h200;
    step();
    i_branchTaken = 0; i_halt = 1; #1;
    chk("hp_wait_pcload", o_pcLoad, 0);
    step();
    i_halt = 0; i_exStallReq = 0; #1;
    chk("hp_pcload", o_pcLoad, 1);
    chk("hp_newpc", o_newPc, 32'h200);
    step(); #1;
    chk("hp_drain_stall", o_stall, 5'b00001);
    chk("hp_drain_flush", o_flush, 1);

    // Watchdog at limit 8
    do_reset();
    i_exStallReq = 1;
    for (int i = 1; i <= 7; i++) step();
    chk("wdog_7", o_timeout, 0);
    step();
    chk("wdog_8", o_timeout, 1);
    i_exStallReq = 0;
    step();
    chk("wdog_sticky", o_timeout, 1);
    rst = 1;
    step();
    chk("wdog_rst", o_timeout, 0);
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
